// File: rtl/hv_cmdq_pkg.sv
// hv_cmdq_pkg: shared constants and types for the HV command queue
package hv_cmdq_pkg;
  localparam logic [7:0] ST_IDLE = 8'h00;
  localparam logic [7:0] ST_QUEUED = 8'h01;
  localparam logic [7:0] ST_ISSUED = 8'h02;
  localparam int CSUM_OFS = 128;
  localparam int ERR_CSUM = 0;
  localparam int ERR_FRAME = 1;
  localparam int ERR_OVF = 2;
  typedef enum logic {EG_IDLE, EG_STREAM} eg_state_t;
endpackage

// File: rtl/hv_cdb_checksum.sv
// hv_cdb_checksum: checksum word must equal the XOR of every other 32-bit word
module hv_cdb_checksum
  import hv_cmdq_pkg::*;
#(
  parameter int CDB_WIDTH = 256
) (
  input  logic [CDB_WIDTH-1:0] cdb,
  output logic                 match
);
  localparam int NW = CDB_WIDTH / 32;
  localparam int CW = CSUM_OFS / 32;
  logic [31:0] acc;
  always_comb begin
    acc = '0;
    for (int i = 0; i < NW; i++) acc = (i != CW) ? acc ^ cdb[i*32 +: 32] : acc;
  end
  assign match = acc == cdb[CSUM_OFS +: 32];
endmodule

// File: rtl/hv_cmdq_chk.sv
// hv_cmdq_chk: checksummed CDB FIFO with beat-serial ingress/egress,
// framing/overflow detection and a per-tag status table.
module hv_cmdq_chk
  import hv_cmdq_pkg::*;
#(
  parameter int CMD_IO_WIDTH = 64,
  parameter int CDB_WIDTH = 256,
  parameter int DEPTH = 8,
  parameter int TAG_WIDTH = 8
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    cmd_ie,
  input  logic [CMD_IO_WIDTH-1:0] cmd_in,
  output logic                    cq_cin_ready,
  input  logic                    cmd_request,
  output logic                    cq_cout_ready,
  output logic                    cmd_oe,
  output logic [CMD_IO_WIDTH-1:0] cmd_out,
  input  logic                    op_status_we,
  input  logic [TAG_WIDTH-1:0]    op_tag,
  input  logic [7:0]              cmd_op_status,
  input  logic                    query_ie,
  input  logic [TAG_WIDTH-1:0]    query_tag,
  output logic                    query_oe,
  output logic [CMD_IO_WIDTH-1:0] query_out,
  output logic [2:0]              err_pulse
);
  localparam int BEATS = CDB_WIDTH / CMD_IO_WIDTH;
  localparam int KW = BEATS > 1 ? $clog2(BEATS) : 1;
  localparam int PW = $clog2(DEPTH);
  logic [KW-1:0] k, eb;
  logic [CDB_WIDTH-1:0] asm_q, out_q;
  logic [CDB_WIDTH-1:0] mem [DEPTH];
  logic [7:0] st [2**TAG_WIDTH];
  logic [PW-1:0] wr, rd;
  logic [PW:0] count;
  logic [TAG_WIDTH-1:0] head_tag;
  logic drop_q, pend, match, first, last, eb_last, drop_now, push, pop;
  eg_state_t state, state_nx;

  hv_cdb_checksum #(.CDB_WIDTH(CDB_WIDTH)) u_csum (.cdb(asm_q), .match(match));

  assign first = k == '0;
  assign last = k == KW'(BEATS - 1);
  assign eb_last = eb == KW'(BEATS - 1);
  assign drop_now = first ? !cq_cin_ready : drop_q;
  assign head_tag = mem[rd][8 +: TAG_WIDTH];
  assign cq_cin_ready = count < (PW+1)'(DEPTH);
  assign cq_cout_ready = count != '0 && state == EG_IDLE;
  assign pop = cmd_request && cq_cout_ready;
  // a full FIFO still takes the assembled CDB when the head leaves in the same cycle
  assign push = pend && match && (count != (PW+1)'(DEPTH) || pop);
  assign err_pulse[ERR_CSUM] = pend && !match;
  assign err_pulse[ERR_FRAME] = !cmd_ie && !first;
  assign err_pulse[ERR_OVF] = (cmd_ie && last && drop_now) || (pend && match && !push);
  assign cmd_oe = state == EG_STREAM;
  assign cmd_out = cmd_oe ? out_q[eb*CMD_IO_WIDTH +: CMD_IO_WIDTH] : '0;

  always_comb state_nx = (state == EG_IDLE) ? (pop ? EG_STREAM : EG_IDLE) : (eb_last ? EG_IDLE : EG_STREAM);

  always_ff @(posedge clk) state <= reset ? EG_IDLE : state_nx;

  always_ff @(posedge clk) begin
    if (cmd_ie) asm_q[k*CMD_IO_WIDTH +: CMD_IO_WIDTH] <= cmd_in;
    if (push) mem[wr] <= asm_q;
    if (pop) out_q <= mem[rd];
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      k <= '0;
      eb <= '0;
      drop_q <= 1'b0;
      pend <= 1'b0;
      wr <= '0;
      rd <= '0;
      count <= '0;
      query_oe <= 1'b0;
      query_out <= '0;
      for (int i = 0; i < 2**TAG_WIDTH; i++) st[i] <= ST_IDLE;
    end else begin
      pend <= cmd_ie && last && !drop_now;
      k <= (cmd_ie && !last) ? k + KW'(1) : '0;
      if (cmd_ie && first) drop_q <= !cq_cin_ready;
      eb <= (cmd_oe && !eb_last) ? eb + KW'(1) : '0;
      count <= count + (PW+1)'(push) - (PW+1)'(pop);
      query_oe <= query_ie;
      query_out <= query_ie ? CMD_IO_WIDTH'({query_tag, st[query_tag]}) : '0;
      // later writes win: op_status_we > dispatch > accept
      if (push) begin
        wr <= wr + PW'(1);
        st[asm_q[8 +: TAG_WIDTH]] <= ST_QUEUED;
      end
      if (pop) begin
        rd <= rd + PW'(1);
        st[head_tag] <= ST_ISSUED;
      end
      if (op_status_we) st[op_tag] <= cmd_op_status;
    end
  end
endmodule

// File: doc/hv_cmdq_chk.md
Name: hv_cmdq_chk

Overview:
- Parametrised successor of the HV command queue: beat-serial CDB ingress, DEPTH-entry CDB FIFO, beat-serial egress on request.
- New over the previous generation:
  - programmable CDB/IO width and queue depth;
  - CDB checksum validation with drop-and-flag;
  - framing and overflow error detection;
  - per-tag status table readable through the query port.
- Sits between the host command decoder (ingress) and the HV operation engine (egress, status write-back).

Parameters:
- CMD_IO_WIDTH, 64, beat width in bits; must divide CDB_WIDTH.
- CDB_WIDTH, 256, command descriptor block width; multiple of 64, at least 192.
- DEPTH, 8, FIFO entries (whole CDBs); power of two, at least 2.
- TAG_WIDTH, 8, tag field width; tag is CDB bits [8 +: TAG_WIDTH].

Ports:
- clk  in  1  single clock, rising edge.
- reset  in  1  synchronous, active-high.
- cmd_ie  in  1  ingress beat valid.
- cmd_in  in  CMD_IO_WIDTH  ingress beat, LSB beat first.
- cq_cin_ready  out  1  space for one full CDB.
- cmd_request  in  1  one-cycle dispatch request.
- cq_cout_ready  out  1  CDB available and egress idle.
- cmd_oe  out  1  egress beat valid.
- cmd_out  out  CMD_IO_WIDTH  egress beat, LSB beat first.
- op_status_we  in  1  status write strobe.
- op_tag  in  TAG_WIDTH  tag written.
- cmd_op_status  in  8  status value written.
- query_ie  in  1  query strobe.
- query_tag  in  TAG_WIDTH  tag queried.
- query_oe  out  1  query response valid.
- query_out  out  CMD_IO_WIDTH  {zero pad, tag, status byte}; status in [7:0], tag in [8 +: TAG_WIDTH].
- err_pulse  out  3  one-cycle flags {overflow, frame, checksum}.

Behaviour:
- BEATS = CDB_WIDTH/CMD_IO_WIDTH.
- Reset (synchronous, active-high):
  - FIFO pointers and count, beat counters, egress FSM and all status entries cleared.
  - Outputs cq_cin_ready=1, cq_cout_ready=0, cmd_oe=0, cmd_out=0, query_oe=0, query_out=0, err_pulse=0.
  - Reset mid-ingress or mid-egress aborts the transfer; no partial entry is kept.
- Ingress:
  - Beat counter 0..BEATS-1; each cmd_ie cycle writes cmd_in into assembly slice [k*CMD_IO_WIDTH +: CMD_IO_WIDTH].
  - Beats must be on consecutive cycles. cmd_ie low while 0<k<BEATS: partial CDB discarded, k:=0, err_pulse[1] for one cycle.
  - cq_cin_ready sampled on the first beat only. If it is 0, the whole CDB is consumed and dropped, with err_pulse[2] on the last beat.
  - Checksum, evaluated on the last beat: word W4 = bits [159:128] must equal the XOR of all other 32-bit words of the CDB.
  - On mismatch: CDB dropped, err_pulse[0] on the cycle after the last beat, status untouched.
  - On match: CDB pushed and count incremented the cycle after the last beat; status[tag] := 8'h01 (QUEUED).
- Egress FSM, states IDLE, STREAM:
  - cq_cout_ready = (count!=0) && IDLE.
  - IDLE: cmd_request && cq_cout_ready -> STREAM. cmd_oe=1 from the next cycle for exactly BEATS consecutive cycles, head CDB beat 0 first.
  - On entering STREAM, the FIFO pops and status[tag] := 8'h02 (ISSUED).
  - cmd_request while not ready, or during STREAM, is ignored.
  - STREAM -> IDLE after beat BEATS-1. cmd_out holds 0 when cmd_oe=0.
- Simultaneous events:
  - Push and pop in the same cycle: count unchanged; a full FIFO may accept that push.
  - Status writes to the same tag in one cycle, priority: op_status_we > dispatch > accept.
- Status table: 2^TAG_WIDTH x 8 bits, reset 8'h00 (IDLE). op_status_we writes cmd_op_status unconditionally.
- Query:
  - query_oe asserts exactly 1 cycle after query_ie.
  - query_out reports status[query_tag] as of the query cycle, i.e. before that cycle's writes.
  - Back-to-back queries give back-to-back responses.
- Pointers wrap modulo DEPTH. Count width is clog2(DEPTH)+1. Full at count==DEPTH.

Decomposition:
- Shared package hv_cmdq_pkg holds:
  - status constants ST_IDLE=8'h00, ST_QUEUED=8'h01, ST_ISSUED=8'h02;
  - checksum word offset (128);
  - error-bit indices;
  - egress state enum.
- One sub-module, hv_cdb_checksum: combinational CDB_WIDTH -> match bit, instanced at the ingress assembly register.

Test Plan:
- Reset, then three valid CDBs (tags 0,1,2) -> count=3, query tag1 returns 8'h01.
- Three cmd_request pulses -> each gives 4 beats of the original CDB in order; query tag1 returns 8'h02.
- CDB with W4 corrupted by 32'h1 -> err_pulse=3'b001, count unchanged, query returns 8'h00.
- cmd_ie dropped after 2 beats, then a valid CDB -> err_pulse=3'b010; the valid CDB is accepted intact.
- Fill 8 entries, then a 9th CDB -> err_pulse=3'b100, cq_cin_ready=0. Next, request and push in the same cycle -> count stays 8.
- op_status_we with tag 5, value 8'hA5, same cycle as query tag 5 -> response 8'h01 (old value). Next query -> 8'hA5. Reset asserted mid-STREAM -> cmd_oe=0 next cycle.
